// File: rtl/simd_pkg.sv
// Shared opcode and FSM state definitions for the SIMD instruction sequencer.
package simd_pkg;

  localparam int OPCODE_WIDTH = 3;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    OP_NOP    = 3'd0,
    OP_VOP    = 3'd1,
    OP_DOT    = 3'd2,
    OP_DOTW   = 3'd3,
    OP_SHIFT  = 3'd4,
    OP_REPEAT = 3'd5,
    OP_RSVD   = 3'd6,
    OP_HALT   = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_DONE
  } state_e;

  function automatic logic is_issuing(input opcode_e op);
    return op inside {OP_VOP, OP_DOT, OP_DOTW, OP_SHIFT};
  endfunction

endpackage

// File: rtl/ins_mem.sv
// Instruction store: single write port, registered (synchronous) read port.
module ins_mem #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 36
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Array has no reset so a loaded program survives rst; only the read register clears.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/simd_ins_sequencer.sv
// Fetches instructions from a local program store and issues SIMD micro-ops,
// expanding REPEAT prefixes into address-incrementing bursts.
module simd_ins_sequencer
  import simd_pkg::*;
#(
  parameter int INS_ADDR_WIDTH = 8,
  parameter int ADDR_WIDTH     = 10,
  parameter int OP_SEL_WIDTH   = 2,
  parameter int NUM_R_BANKS    = 2,
  parameter int REP_WIDTH      = 8,
  localparam int R_SEL_WIDTH   = (NUM_R_BANKS > 2) ? $clog2(NUM_R_BANKS) : 1,
  localparam int INS_WIDTH     = OPCODE_WIDTH + OP_SEL_WIDTH + R_SEL_WIDTH + 3*ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      overrun,
  input  logic                      ins_we,
  input  logic [INS_ADDR_WIDTH-1:0] ins_waddr,
  input  logic [INS_WIDTH-1:0]      ins_wdata,
  output logic                      issue_valid,
  input  logic                      issue_ready,
  output logic [ADDR_WIDTH-1:0]     a_addr,
  output logic [ADDR_WIDTH-1:0]     b_addr,
  output logic [ADDR_WIDTH-1:0]     r_addr,
  output logic [OP_SEL_WIDTH-1:0]   pe_op,
  output logic                      dot_prod_en,
  output logic                      shift,
  output logic                      write_en,
  output logic [R_SEL_WIDTH-1:0]    r_select
);

  state_e                    state;
  logic [INS_ADDR_WIDTH:0]   pc;
  logic [INS_WIDTH-1:0]      ins_reg;
  logic [REP_WIDTH-1:0]      rep_cnt;
  logic [REP_WIDTH-1:0]      idx;
  logic [REP_WIDTH-1:0]      rep_total;
  logic [REP_WIDTH-1:0]      rep_load;
  logic [OPCODE_WIDTH-1:0]   opcode_bits;
  opcode_e                   opcode;
  logic [OP_SEL_WIDTH-1:0]   op_sel;
  logic [R_SEL_WIDTH-1:0]    r_sel;
  logic [ADDR_WIDTH-1:0]     a_f;
  logic [ADDR_WIDTH-1:0]     b_f;
  logic [ADDR_WIDTH-1:0]     r_f;
  logic                      issuing;
  logic                      last_iter;
  logic                      pc_end;
  state_e                    exec_next;

  assign {opcode_bits, op_sel, r_sel, a_f, b_f, r_f} = ins_reg;
  assign opcode = opcode_e'(opcode_bits);

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // ins_reg is the memory's read register, loaded only in FETCH.
  ins_mem #(
    .ADDR_WIDTH (INS_ADDR_WIDTH),
    .DATA_WIDTH (INS_WIDTH)
  ) u_ins_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (ins_we && (state == S_IDLE)),
    .waddr (ins_waddr),
    .wdata (ins_wdata),
    .re    (state == S_FETCH),
    .raddr (pc[INS_ADDR_WIDTH-1:0]),
    .rdata (ins_reg)
  );

  assign rep_total = (rep_cnt == '0) ? REP_WIDTH'(1) : rep_cnt;
  assign rep_load  = (b_f[REP_WIDTH-1:0] == '0) ? REP_WIDTH'(1) : b_f[REP_WIDTH-1:0];
  assign last_iter = (idx == rep_total - REP_WIDTH'(1));
  assign issuing   = (state == S_EXEC) && is_issuing(opcode);
  // pc carries one extra bit so running past the last address is detected rather than wrapped.
  assign pc_end    = pc[INS_ADDR_WIDTH];
  assign exec_next = pc_end ? S_DONE : S_FETCH;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      pc      <= '0;
      rep_cnt <= '0;
      idx     <= '0;
      overrun <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            pc      <= '0;
            rep_cnt <= '0;
            idx     <= '0;
            overrun <= 1'b0;
            state   <= S_FETCH;
          end
        end
        S_FETCH: begin
          pc    <= pc + 1'b1;
          state <= S_EXEC;
        end
        S_EXEC: begin
          case (opcode)
            OP_HALT: begin
              rep_cnt <= '0;
              state   <= S_DONE;
            end
            OP_REPEAT: begin
              rep_cnt <= rep_load;
              overrun <= pc_end;
              state   <= exec_next;
            end
            OP_VOP, OP_DOT, OP_DOTW, OP_SHIFT: begin
              if (issue_ready) begin
                if (last_iter) begin
                  idx     <= '0;
                  rep_cnt <= '0;
                  overrun <= pc_end;
                  state   <= exec_next;
                end else begin
                  idx <= idx + REP_WIDTH'(1);
                end
              end
            end
            default: begin
              rep_cnt <= '0;
              overrun <= pc_end;
              state   <= exec_next;
            end
          endcase
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Micro-op fields decode straight from registered state so an EXEC cycle can issue
  // immediately after the synchronous fetch.
  always_comb begin
    issue_valid = issuing;
    a_addr      = '0;
    b_addr      = '0;
    r_addr      = '0;
    pe_op       = '0;
    dot_prod_en = 1'b0;
    shift       = 1'b0;
    write_en    = 1'b0;
    r_select    = '0;
    if (issuing) begin
      a_addr      = a_f + ADDR_WIDTH'(idx);
      b_addr      = b_f + ADDR_WIDTH'(idx);
      r_addr      = r_f + ADDR_WIDTH'(idx);
      pe_op       = (opcode == OP_VOP) ? op_sel : '0;
      dot_prod_en = (opcode == OP_DOT) || (opcode == OP_DOTW);
      shift       = (opcode == OP_SHIFT);
      write_en    = (opcode == OP_VOP) || (opcode == OP_DOTW);
      r_select    = r_sel;
    end
  end

endmodule
